mem_reader: RTL and testbench
=============================

Name: mem_reader

Overview:
Read-side sequencer for the 8 x 16 `memory` block. The existing path only writes into it. This block reads it back.
- On a start pulse it walks a range of addresses with R_W=1.
- It captures each D_Out word and presents it on a valid/ready stream toward the downstream consumer (debug dump, UART/display).
- It owns the memory port while busy. An external mux selects it over the write driver when busy=1.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 3, memory address width.
- DEPTH, 8, number of words (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first address to read.
- count  in  ADDR_W+1  number of words to read, 0..DEPTH (values >DEPTH clamp to DEPTH).
- enable  out  1  memory enable.
- R_W  out  1  memory direction; 1=read, 0=write. This block only drives 1 while enable=1.
- Address  out  ADDR_W  memory address.
- D_In  out  DATA_W  memory write data; tied to 0.
- D_Out  in  DATA_W  memory read data, combinational from Address when enable=1 and R_W=1.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address out_data came from.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
Reset values:
- Synchronous reset forces state=IDLE.
- All outputs reset to 0: enable, R_W, Address, D_In, out_data, out_addr, out_valid, busy, done.
- Internal addr_reg and remaining reset to 0.
- Reset mid-burst aborts immediately. There is no done pulse, and the partially sent burst is discarded.

FSM states and transitions:
- IDLE: all memory outputs 0.
  - start=1 and count=0: go to DONE. No memory access, no out_valid.
  - start=1 and count>0: addr_reg<=start_addr, remaining<=min(count,DEPTH), go to READ.
- READ (1 cycle): enable=1, R_W=1, Address=addr_reg.
  - At the clock edge, out_data<=D_Out, out_addr<=addr_reg, go to SEND.
- SEND: out_valid=1, enable=0.
  - out_data and out_addr are held stable while out_ready=0. Backpressure is unbounded.
  - On out_valid & out_ready with remaining=1: go to DONE.
  - Otherwise: remaining<=remaining-1, addr_reg<=addr_reg+1 (mod DEPTH), go to READ.
- DONE (1 cycle): done=1, busy=1, then IDLE.

Latency and throughput:
- Latency: start sampled at edge N → enable at cycle N+1 → out_valid at cycle N+2.
- Best-case throughput with out_ready held at 1: one word per 2 cycles.

Boundary conditions:
- Address wrap: 7+1 → 0. A burst of count=DEPTH reads every word exactly once.
- start while busy is ignored; the current burst is not disturbed.
- start in DONE is ignored.
- The memory port is never driven with R_W=0 by this block. D_In=0 always.
- out_valid never drops without a handshake except on reset.

Decomposition:
- Shared package mem_pkg holds:
  - DATA_W, ADDR_W, DEPTH;
  - RW_READ=1'b1 and RW_WRITE=1'b0;
  - reader state encoding IDLE/READ/SEND/DONE.
- The memory write testbench and any write sequencer reuse the same package.
- No sub-module: a single FSM plus counters.
- The arbitration mux between writer and reader lives at the top level, not in this block.

Test Plan:
1. Preload memory via writes: 0:AAAA 1:1111 2:00AA 3:00BB 4:2222 5:00CC 6:00DD 7:FFFF. Then start, start_addr=0, count=8, out_ready=1 → 8 beats AAAA,1111,00AA,00BB,2222,00CC,00DD,FFFF with out_addr 0..7, one beat every 2 cycles, first out_valid 2 cycles after start, done 1 cycle after the last handshake.
2. Wrap: start_addr=6, count=4 → beats 00DD,FFFF,AAAA,1111 at addresses 6,7,0,1, then done.
3. Backpressure: start_addr=2, count=2, hold out_ready=0 for 3 cycles in SEND → out_valid=1 and out_data=00AA held stable and enable=0 throughout; after release, 00BB follows.
4. count=0 → done pulses 1 cycle after start; out_valid and enable stay 0. count=12 → exactly 8 beats.
5. Reset mid-burst: assert reset during the 3rd SEND of an 8-word burst → next cycle all outputs are 0 and state is IDLE, no done. A fresh start from address 3 then returns 00BB first.
6. Second start pulse while busy (start_addr=5) → ignored; the original burst sequence and its done timing are unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and reader state encoding for the 8 x 16 memory
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/mem_reader.sv
// rtl/mem_reader.sv - burst read sequencer streaming memory words out over valid/ready
module mem_reader
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              enable,
    output logic              R_W,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] D_In,
    input  logic [DATA_W-1:0] D_Out,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    rd_state_t         state, state_nx;
    logic [ADDR_W-1:0] addr_reg, addr_nx;
    logic [ADDR_W:0]   remaining, rem_nx;
    logic              capture;

    assign D_In = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_reg  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            state     <= state_nx;
            addr_reg  <= addr_nx;
            remaining <= rem_nx;
            if (capture) begin
                out_data <= D_Out;
                out_addr <= addr_reg;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = addr_reg;
        rem_nx    = remaining;
        capture   = 1'b0;
        enable    = 1'b0;
        R_W       = RW_WRITE;
        Address   = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (count == '0) begin
                        state_nx = DONE;
                    end else begin
                        addr_nx  = start_addr;
                        rem_nx   = (count > DEPTH_CNT) ? DEPTH_CNT : count;
                        state_nx = READ;
                    end
                end
            end
            READ: begin
                // D_Out is combinational from Address, so the word is captured on this edge
                enable   = 1'b1;
                R_W      = RW_READ;
                Address  = addr_reg;
                capture  = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (remaining == ONE_CNT) begin
                        state_nx = DONE;
                    end else begin
                        rem_nx   = remaining - ONE_CNT;
                        addr_nx  = addr_reg + ADDR_W'(1);
                        state_nx = READ;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_reader.sv
// tb/tb_mem_reader.sv - scoreboard bench for mem_reader with a behavioural 8 x 16 memory
module tb_mem_reader;
    import mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start, out_ready;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              enable, R_W, out_valid, busy, done;
    logic [ADDR_W-1:0] Address, out_addr;
    logic [DATA_W-1:0] D_In, D_Out, out_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              m_en, m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;

    mem_reader dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
        .enable(enable), .R_W(R_W), .Address(Address), .D_In(D_In), .D_Out(D_Out),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Top-level arbitration: the reader owns the port while busy
    assign m_en   = busy ? enable  : wr_en;
    assign m_rw   = busy ? R_W     : RW_WRITE;
    assign m_addr = busy ? Address : wr_addr;
    assign m_din  = busy ? D_In    : wr_data;
    assign D_Out  = (m_en && m_rw) ? mem[m_addr] : '0;

    always @(posedge clk) if (m_en && !m_rw) mem[m_addr] <= m_din;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_t;
    beat_t exp_q[$];
    logic [DATA_W-1:0] img [0:DEPTH-1];

    int n_cmp = 0, n_bad = 0;
    int hs_count = 0, last_hs_cyc = 0;
    int hs_cycles[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("d_in_zero", D_In, 0);
            if (enable) chk("rw_is_read", R_W, 1);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_addr", out_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got addr %0h data %0h expected none", out_addr, out_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_addr", out_addr, b.a);
                    chk("beat_data", out_data, b.d);
                end
                hs_count++;
                last_hs_cyc = cyc;
                hs_cycles.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input int n);
        logic [ADDR_W-1:0] aa;
        aa = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: aa, d: img[aa]});
            aa = aa + 1'b1;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] c);
        start_addr = a; count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int done_cyc);
        bit seen = 0;
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1; done_cyc = cyc; break; end
            tick();
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 200 && hs_count < target; i++) tick();
        chk("wait_hs_reached", hs_count, target);
    endtask

    int s, dc, base;

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; start_addr = '0; count = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        img[0] = 16'hAAAA; img[1] = 16'h1111; img[2] = 16'h00AA; img[3] = 16'h00BB;
        img[4] = 16'h2222; img[5] = 16'h00CC; img[6] = 16'h00DD; img[7] = 16'hFFFF;
        tick(); tick();
        chk("rst_enable", enable, 0);    chk("rst_rw", R_W, 0);
        chk("rst_address", Address, 0);  chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0); chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) mem_wr(ADDR_W'(i), img[i]);

        // Full burst, streaming
        hs_cycles.delete();
        push_exp(3'd0, 8);
        do_start(3'd0, 4'd8);
        s = cyc;
        chk("t1_enable_n1", enable, 1);
        chk("t1_address_n1", Address, 0);
        wait_done("t1", dc);
        chk("t1_beats", hs_cycles.size(), 8);
        if (hs_cycles.size() == 8) begin
            chk("t1_first_valid_lat", hs_cycles[0], s + 1);
            for (int i = 1; i < 8; i++) chk("t1_spacing", hs_cycles[i] - hs_cycles[i-1], 2);
        end
        chk("t1_done_timing", dc, last_hs_cyc + 1);
        chk("t1_busy_in_done", busy, 1);
        tick();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Address wrap
        push_exp(3'd6, 4);
        do_start(3'd6, 4'd4);
        wait_done("t2", dc);
        chk("t2_done_timing", dc, last_hs_cyc + 1);
        tick();
        chk("t2_queue_empty", exp_q.size(), 0);

        // Backpressure
        out_ready = 1'b0;
        exp_q.push_back('{a: 3'd2, d: 16'h00AA});
        exp_q.push_back('{a: 3'd3, d: 16'h00BB});
        do_start(3'd2, 4'd2);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t3_valid_held", out_valid, 1);
            chk("t3_data_held", out_data, 16'h00AA);
            chk("t3_enable_low", enable, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_done("t3", dc);
        chk("t3_done_timing", dc, last_hs_cyc + 1);
        tick();
        chk("t3_queue_empty", exp_q.size(), 0);

        // Zero count, then clamped count
        do_start(3'd4, 4'd0);
        chk("t4_zero_done", done, 1);
        chk("t4_zero_valid", out_valid, 0);
        chk("t4_zero_enable", enable, 0);
        tick();
        chk("t4_zero_done_drop", done, 0);
        chk("t4_zero_idle", busy, 0);
        base = hs_count;
        push_exp(3'd0, 8);
        do_start(3'd0, 4'd12);
        wait_done("t4c", dc);
        tick();
        chk("t4_clamp_beats", hs_count - base, 8);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Reset during the third SEND
        base = hs_count;
        push_exp(3'd0, 8);
        do_start(3'd0, 4'd8);
        wait_hs(base + 2);
        tick();
        chk("t5_in_send", out_valid, 1);
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("t5_enable", enable, 0);     chk("t5_rw", R_W, 0);
        chk("t5_address", Address, 0);   chk("t5_d_in", D_In, 0);
        chk("t5_out_data", out_data, 0); chk("t5_out_addr", out_addr, 0);
        chk("t5_out_valid", out_valid, 0); chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        exp_q.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_done", done, 0);
        end
        exp_q.push_back('{a: 3'd3, d: 16'h00BB});
        do_start(3'd3, 4'd1);
        wait_done("t5", dc);
        tick();
        chk("t5_queue_empty", exp_q.size(), 0);

        // Start while busy is ignored
        base = hs_count;
        push_exp(3'd0, 3);
        do_start(3'd0, 4'd3);
        wait_hs(base + 1);
        start_addr = 3'd5; count = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", dc);
        chk("t6_done_timing", dc, last_hs_cyc + 1);
        tick();
        chk("t6_beats", hs_count - base, 3);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_idle", busy, 0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1);
    end

endmodule
